// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM responder slice.
// Latency: n/a. Backpressure: n/a.
package sram_pkg;

    localparam int          DEPTH_LOG2_DEF = 10;
    localparam logic [15:0] MMIO_ADDR      = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        WR1  = 2'd2,
        WR2  = 2'd3
    } state_t;

endpackage

// File: rtl/sram_word_array.sv
// Byte-enabled 16-bit word storage: synchronous write, registered read.
// Latency: 1 cycle read, write lands on the edge. Backpressure: none.
module sram_word_array #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  Clk,
    input  logic                  wr_en,
    input  logic [1:0]            wr_be,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [15:0]           wr_data,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [15:0]           rd_data
);

    logic [15:0] mem [0:(2**DEPTH_LOG2)-1];

    always_ff @(posedge Clk) begin
        if (wr_en && wr_be[1]) mem[wr_addr][15:8] <= wr_data[15:8];
        if (wr_en && wr_be[0]) mem[wr_addr][7:0]  <= wr_data[7:0];
        if (rd_en)             rd_data            <= mem[rd_addr];
    end

endmodule

// File: rtl/sram_responder.sv
// SRAM-protocol responder with optional switch/hex MMIO word (SRAM_MMIO_EN).
// Latency: read data valid 1 cycle after OE low; write commits 2 cycles after WE low. Backpressure: none.
module sram_responder
    import sram_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Mem_CE,
    input  logic        Mem_OE,
    input  logic        Mem_WE,
    input  logic        Mem_UB,
    input  logic        Mem_LB,
    input  logic [19:0] ADDR,
    input  logic [15:0] Data_to_SRAM,
    input  logic [15:0] Switches,
    output logic [15:0] Data_from_SRAM,
    output logic        Data_valid,
    output logic [15:0] Hex_out,
    output logic        Err
);

    state_t      state, state_nxt;
    logic        err_nxt;
    logic        access, want_wr, want_rd;
    logic        is_mmio, rd_fire, commit;
    logic [1:0]  lane_en, rd_lanes_q;
    logic [15:0] arr_q, rd_word;
    logic        unused_bits;

    assign access  = !Mem_CE;
    assign want_wr = !Mem_WE;
    assign want_rd = !Mem_OE && Mem_WE;
    assign lane_en = {!Mem_UB, !Mem_LB};

`ifdef SRAM_MMIO_EN
    assign is_mmio = (ADDR[15:0] == MMIO_ADDR);
`else
    assign is_mmio = 1'b0;
`endif

    assign rd_fire = Reset_n && access && want_rd && (state == IDLE || state == READ);
    assign commit  = Reset_n && access && (state == WR2);

    // Write wins over a simultaneous OE; the conflict is flagged when the write starts.
    always_comb begin
        state_nxt = IDLE;
        err_nxt   = 1'b0;
        if (access) begin
            case (state)
                IDLE, READ: begin
                    if (want_wr) begin
                        state_nxt = WR1;
                        err_nxt   = !Mem_OE;
                    end else if (want_rd) begin
                        state_nxt = READ;
                    end
                end
                WR1: begin
                    if (want_wr) state_nxt = WR2;
                    else         err_nxt   = 1'b1;
                end
                WR2: begin
                    if (want_wr) begin
                        state_nxt = WR1;
                        err_nxt   = !Mem_OE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state      <= IDLE;
            Err        <= 1'b0;
            Data_valid <= 1'b0;
            rd_lanes_q <= 2'b00;
        end else begin
            state      <= state_nxt;
            Err        <= err_nxt;
            Data_valid <= rd_fire;
            if (rd_fire) rd_lanes_q <= lane_en;
        end
    end

    sram_word_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .Clk     (Clk),
        .wr_en   (commit && !is_mmio),
        .wr_be   (lane_en),
        .wr_addr (ADDR[DEPTH_LOG2-1:0]),
        .wr_data (Data_to_SRAM),
        .rd_en   (rd_fire),
        .rd_addr (ADDR[DEPTH_LOG2-1:0]),
        .rd_data (arr_q)
    );

`ifdef SRAM_MMIO_EN
    logic        rd_mmio_q;
    logic [15:0] sw_q;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            rd_mmio_q <= 1'b0;
            sw_q      <= 16'h0000;
            Hex_out   <= 16'h0000;
        end else begin
            if (rd_fire) begin
                rd_mmio_q <= is_mmio;
                sw_q      <= Switches;
            end
            if (commit && is_mmio && lane_en[1]) Hex_out[15:8] <= Data_to_SRAM[15:8];
            if (commit && is_mmio && lane_en[0]) Hex_out[7:0]  <= Data_to_SRAM[7:0];
        end
    end

    assign rd_word = rd_mmio_q ? sw_q : arr_q;
`else
    assign Hex_out = 16'h0000;
    assign rd_word = arr_q;
`endif

    // Lane mask is held with the data, so a cleared mask also forces the reset value of 0.
    assign Data_from_SRAM = {rd_lanes_q[1] ? rd_word[15:8] : 8'h00,
                             rd_lanes_q[0] ? rd_word[7:0]  : 8'h00};

    assign unused_bits = ^{Switches, ADDR};

endmodule
